// File: rtl/f_pc_sequencer.sv
// Fetch-stage PC sequencer: owns F_PC, runs the req/ack instruction fetch and
// holds the fetched word for decode, honouring flushes and delay-slot redirects.
module f_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_instr,
    output logic        F_valid,
    output logic        F_adel
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned SW   = 2;

    localparam logic [SW-1:0] S_BOOT  = 2'd0;
    localparam logic [SW-1:0] S_ISSUE = 2'd1;
    localparam logic [SW-1:0] S_DRAIN = 2'd2;
    localparam logic [SW-1:0] S_VALID = 2'd3;

    logic [SW-1:0]   state, state_nx;
    logic [XLEN-1:0] f_pc_nx, f_instr_nx, pend_pc_nx, pend_pc;
    logic            f_adel_nx, pend_valid, pend_valid_nx;
    logic            flush, misaligned;
    logic [XLEN-1:0] flush_pc;

    assign flush      = exc_valid | eret_valid;
    assign flush_pc   = exc_valid ? EXC_PC : epc;
    assign misaligned = (F_PC[1:0] != 2'b00);

    // A misaligned PC never reaches the memory; it is reported as F_adel instead.
    assign imem_req  = (state == S_ISSUE) && !misaligned;
    assign imem_addr = F_PC;
    assign F_valid   = (state == S_VALID);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_BOOT;
            F_PC       <= RESET_PC;
            F_instr    <= '0;
            F_adel     <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            state      <= state_nx;
            F_PC       <= f_pc_nx;
            F_instr    <= f_instr_nx;
            F_adel     <= f_adel_nx;
            pend_valid <= pend_valid_nx;
            pend_pc    <= pend_pc_nx;
        end
    end

    // Next-state logic. In DRAIN, pend_pc carries the flush target instead of a redirect.
    always_comb begin
        state_nx      = state;
        f_pc_nx       = F_PC;
        f_instr_nx    = F_instr;
        f_adel_nx     = F_adel;
        pend_valid_nx = pend_valid;
        pend_pc_nx    = pend_pc;

        case (state)
            S_BOOT: begin
                state_nx = S_ISSUE;
                if (flush) begin
                    f_pc_nx       = flush_pc;
                    pend_valid_nx = 1'b0;
                    f_adel_nx     = 1'b0;
                end else if (redir_valid) begin
                    pend_valid_nx = 1'b1;
                    pend_pc_nx    = redir_pc;
                end
            end

            S_ISSUE: begin
                if (flush) begin
                    pend_valid_nx = 1'b0;
                    f_adel_nx     = 1'b0;
                    if (misaligned || imem_ack) begin
                        f_pc_nx = flush_pc;
                    end else begin
                        // Accepted fetch must still complete before refetching.
                        pend_pc_nx = flush_pc;
                        state_nx   = S_DRAIN;
                    end
                end else begin
                    if (redir_valid) begin
                        pend_valid_nx = 1'b1;
                        pend_pc_nx    = redir_pc;
                    end
                    if (misaligned) begin
                        f_instr_nx = '0;
                        f_adel_nx  = 1'b1;
                        state_nx   = S_VALID;
                    end else if (imem_ack) begin
                        f_instr_nx = imem_rdata;
                        f_adel_nx  = 1'b0;
                        state_nx   = S_VALID;
                    end
                end
            end

            S_DRAIN: begin
                if (flush) begin
                    pend_pc_nx    = flush_pc;
                    pend_valid_nx = 1'b0;
                    f_adel_nx     = 1'b0;
                end
                if (imem_ack) begin
                    f_pc_nx  = flush ? flush_pc : pend_pc;
                    state_nx = S_ISSUE;
                end
            end

            S_VALID: begin
                if (flush) begin
                    f_pc_nx       = flush_pc;
                    pend_valid_nx = 1'b0;
                    f_adel_nx     = 1'b0;
                    state_nx      = S_ISSUE;
                end else if (!stall_i) begin
                    // Delay slot is consumed now; the redirect applies to the next fetch.
                    f_pc_nx       = redir_valid ? redir_pc
                                  : (pend_valid ? pend_pc : F_PC + XLEN'(4));
                    pend_valid_nx = 1'b0;
                    state_nx      = S_ISSUE;
                end else if (redir_valid) begin
                    pend_valid_nx = 1'b1;
                    pend_pc_nx    = redir_pc;
                end
            end

            default: state_nx = S_BOOT;
        endcase
    end

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Bench for f_pc_sequencer: variable-latency memory, directed scenarios and a
// random phase, every cycle compared against a phase-level reference model.
module tb_f_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, redir_valid, exc_valid, eret_valid;
    logic [31:0] redir_pc, epc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] F_PC, F_instr;
    logic        F_valid, F_adel;

    f_pc_sequencer #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .exc_valid(exc_valid), .eret_valid(eret_valid), .epc(epc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .F_PC(F_PC), .F_instr(F_instr), .F_valid(F_valid), .F_adel(F_adel)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // What the fetch slot is doing, seen from outside.
    typedef enum int {BOOTING, FETCHING, DISCARDING, HOLDING} phase_t;
    phase_t      m_phase;
    logic [31:0] m_pc, m_instr, m_next_pc, m_flush_pc;
    logic        m_adel, m_next_known;

    // Memory: accepts on a visible request, answers after mem_lat cycles (0 = same cycle).
    int          mem_lat;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_data;
    logic [31:0] acc_q[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_phase      = BOOTING;
        m_pc         = RESET_PC;
        m_instr      = '0;
        m_adel       = 1'b0;
        m_next_known = 1'b0;
        m_next_pc    = '0;
        m_flush_pc   = '0;
        mem_busy     = 1'b0;
        mem_cnt      = 0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
    endtask

    task automatic check_outputs();
        logic exp_req;
        exp_req = (m_phase == FETCHING) && (m_pc[1:0] == 2'b00);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", imem_addr, m_pc);
        check("F_valid", 32'(F_valid), 32'(m_phase == HOLDING));
        check("F_PC", F_PC, m_pc);
        check("F_adel", 32'(F_adel), 32'(m_adel));
        if (m_phase == HOLDING) check("F_instr", F_instr, m_instr);
    endtask

    task automatic mem_drive();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data;
                mem_busy   = 1'b0;
            end
        end else if (imem_req) begin
            acc_q.push_back(imem_addr);
            mem_data = word_of(imem_addr);
            if (mem_lat == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data;
            end else begin
                mem_busy = 1'b1;
                mem_cnt  = mem_lat;
            end
        end
    endtask

    // One clock: check outputs, drive inputs, advance the model across the edge.
    task automatic step(input logic st, input logic rv, input logic [31:0] rp,
                        input logic ex, input logic er, input logic [31:0] ep);
        phase_t      ph;
        logic [31:0] pc, ins, npc, fpc, tgt;
        logic        adel, nk, fl;
        @(negedge clk);
        check_outputs();
        stall_i = st; redir_valid = rv; redir_pc = rp;
        exc_valid = ex; eret_valid = er; epc = ep;
        mem_drive();
        ph = m_phase; pc = m_pc; ins = m_instr; adel = m_adel;
        nk = m_next_known; npc = m_next_pc; fpc = m_flush_pc;
        fl  = ex | er;
        tgt = ex ? EXC_PC : ep;
        if (fl) begin
            nk = 1'b0;
            adel = 1'b0;
        end
        case (m_phase)
            BOOTING: begin
                ph = FETCHING;
                if (fl) pc = tgt;
                else if (rv) begin nk = 1'b1; npc = rp; end
            end
            FETCHING: begin
                if (fl) begin
                    if (m_pc[1:0] != 2'b00 || imem_ack) pc = tgt;
                    else begin fpc = tgt; ph = DISCARDING; end
                end else begin
                    if (rv) begin nk = 1'b1; npc = rp; end
                    if (m_pc[1:0] != 2'b00) begin
                        ins = '0; adel = 1'b1; ph = HOLDING;
                    end else if (imem_ack) begin
                        ins = word_of(m_pc); adel = 1'b0; ph = HOLDING;
                    end
                end
            end
            DISCARDING: begin
                if (fl) fpc = tgt;
                if (imem_ack) begin pc = fpc; ph = FETCHING; end
            end
            HOLDING: begin
                if (fl) begin
                    pc = tgt; ph = FETCHING;
                end else if (!st) begin
                    pc = rv ? rp : (m_next_known ? m_next_pc : m_pc + 32'd4);
                    nk = 1'b0;
                    ph = FETCHING;
                end else if (rv) begin
                    nk = 1'b1; npc = rp;
                end
            end
            default: ph = BOOTING;
        endcase
        @(posedge clk);
        #1;
        m_phase = ph; m_pc = pc; m_instr = ins; m_adel = adel;
        m_next_known = nk; m_next_pc = npc; m_flush_pc = fpc;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!F_valid && n < budget) begin
            idle();
            n++;
        end
        check("wait_valid", 32'(F_valid), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        stall_i = 1'b0; redir_valid = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
        redir_pc = '0; epc = '0;
        model_reset();
        acc_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] r, rp, ep;
        reset = 1'b0;
        mem_lat = 0;
        model_reset();
        stall_i = 1'b0; redir_valid = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
        redir_pc = '0; epc = '0;
        #12;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(F_valid), 32'd0);
        check("rst_pc", F_PC, RESET_PC);
        check("rst_instr", F_instr, 32'd0);
        check("rst_adel", 32'(F_adel), 32'd0);

        // Single-cycle memory after reset: sequential fetches, valid two edges after release.
        do_reset();
        idle();
        check("boot_not_valid", 32'(F_valid), 32'd0);
        idle();
        check("valid_at_2", 32'(F_valid), 32'd1);
        idle(); wait_valid(4);
        idle(); wait_valid(4);
        check("seq_len", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() >= 3) begin
            check("seq0", acc_q[0], 32'h3000);
            check("seq1", acc_q[1], 32'h3004);
            check("seq2", acc_q[2], 32'h3008);
        end

        // Slow memory plus a two-cycle stall while holding.
        mem_lat = 3;
        idle(); wait_valid(8);
        check("slow_pc", F_PC, 32'h300C);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("stall_pc", F_PC, 32'h300C);
        check("stall_instr", F_instr, word_of(32'h300C));
        mem_lat = 0;
        idle(); wait_valid(4);
        check("after_stall_pc", F_PC, 32'h3010);

        // Redirect at the consume edge, then the same redirect parked during ISSUE.
        step(1'b0, 1'b1, 32'h3400, 1'b0, 1'b0, 32'h0);
        wait_valid(4);
        check("redir_now", F_PC, 32'h3400);
        mem_lat = 2;
        idle();
        step(1'b0, 1'b1, 32'h3400, 1'b0, 1'b0, 32'h0);
        wait_valid(6);
        check("slot_pc", F_PC, 32'h3404);
        idle(); wait_valid(6);
        check("redir_pend", F_PC, 32'h3400);

        // Exception while a fetch is outstanding; exc beats eret.
        step(1'b0, 1'b1, 32'h3020, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("drain_valid", 32'(F_valid), 32'd0);
        check("drain_req", 32'(imem_req), 32'd0);
        wait_valid(8);
        check("exc_pc", F_PC, EXC_PC);
        check("exc_addr", acc_q[$], EXC_PC);
        mem_lat = 0;
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3100);
        wait_valid(4);
        check("exc_eret_pc", F_PC, EXC_PC);

        // ERET to a misaligned address, then an exception clears the error.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3102);
        check("adel_noreq", 32'(imem_req), 32'd0);
        wait_valid(4);
        check("adel_flag", 32'(F_adel), 32'd1);
        check("adel_instr", F_instr, 32'd0);
        check("adel_pc", F_PC, 32'h3102);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        wait_valid(4);
        check("adel_clr_pc", F_PC, EXC_PC);
        check("adel_clr", 32'(F_adel), 32'd0);

        // PC+4 wraps at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        wait_valid(4);
        idle(); wait_valid(4);
        check("wrap_pc", F_PC, 32'h0000_0000);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            mem_lat = $urandom_range(0, 3);
            r  = $urandom;
            rp = (r[3:0] == 4'd0) ? r : {r[31:2], 2'b00};
            r  = $urandom;
            ep = (r[3:0] == 4'd0) ? r : {r[31:2], 2'b00};
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2), rp,
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0), ep);
        end

        // Asynchronous reset while fetching 0x3008 under stall with a parked redirect.
        do_reset();
        mem_lat = 3;
        wait_valid(8);
        idle(); wait_valid(8);
        idle();
        step(1'b1, 1'b1, 32'h5000, 1'b0, 1'b0, 32'h0);
        check("pre_rst_req", 32'(imem_req), 32'd1);
        check("pre_rst_addr", imem_addr, 32'h3008);
        #2;
        reset = 1'b0;
        #1;
        check("async_req", 32'(imem_req), 32'd0);
        check("async_pc", F_PC, RESET_PC);
        check("async_valid", 32'(F_valid), 32'd0);
        do_reset();
        mem_lat = 0;
        wait_valid(4);
        check("post_rst_pc", F_PC, RESET_PC);
        idle(); wait_valid(4);
        check("pend_cleared", F_PC, 32'h3004);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
